// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction-memory controller.
//
// Arbitrates the CPU fetch port (read) against the program-loader port
// (write) onto a single-ported, synchronous-read instruction RAM. Word
// addresses are range checked against [BASE, BASE+DEPTH) and turned into
// memory-local offsets.
//
// Optional build macro: NULL_HALT_EN
//   defined   : a fetched zero word latches a halt (halted, halt_addr); no
//               further fetch is granted until halt_clr. Loads are still served.
//   undefined : zero words are ordinary data; halted/halt_addr read as 0.
//
// Handshake: a requester raises *_req with its address/data and holds all of
// them until the one-cycle fetch_valid/load_ack pulse. A request still high
// in the cycle after that pulse is a new request.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   fetch_req/fetch_addr            fetch request (30-bit word address)
//   fetch_valid/fetch_data/fetch_err fetch response pulse, data, range error
//   load_req/load_addr/load_data    loader write request
//   load_ack/load_err               loader response pulse, range error
//   halt_clr, halted, halt_addr     null-op halt control/status
//   mem_en/mem_we/mem_addr/mem_wdata RAM command (registered)
//   mem_rdata                       RAM read data, one cycle after a read
//   dbg_state                       current FSM state for observation

module imem_ctrl #(
  parameter logic [29:0] BASE  = 30'h00100000,
  parameter int unsigned DEPTH = 145,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fetch_req,
  input  logic [29:0]   fetch_addr,
  output logic          fetch_valid,
  output logic [31:0]   fetch_data,
  output logic          fetch_err,
  input  logic          load_req,
  input  logic [29:0]   load_addr,
  input  logic [31:0]   load_data,
  output logic          load_ack,
  output logic          load_err,
  input  logic          halt_clr,
  output logic          halted,
  output logic [29:0]   halt_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [2:0]    dbg_state
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_ACC = 3'd1,
    F_RSP = 3'd2,
    L_WR  = 3'd3,
    HALT  = 3'd4
  } state_e;

  state_e          state_q;
  logic            rd_wait_q;    // F_ACC second cycle: RAM data is on mem_rdata
  logic            last_load_q;  // 1: last grant went to the loader
  logic            ret_halt_q;   // L_WR entered from HALT, return there
  logic            clr_pend_q;   // halt_clr seen together with a load in HALT
  logic            halted_q;
  logic            fetch_valid_q;
  logic [31:0]     fetch_data_q;
  logic            fetch_err_q;
  logic            load_ack_q;
  logic            load_err_q;
  logic            mem_en_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [31:0]     mem_wdata_q;
`ifdef NULL_HALT_EN
  logic [29:0]     halt_addr_q;
`endif

  // Address translation and bounds check (30-bit unsigned).
  logic [29:0] f_off;
  logic [29:0] l_off;
  logic        f_in;
  logic        l_in;

  assign f_off = fetch_addr - BASE;
  assign l_off = load_addr - BASE;
  assign f_in  = (fetch_addr >= BASE) && (f_off < DEPTH_W);
  assign l_in  = (load_addr >= BASE) && (l_off < DEPTH_W);

  // Round-robin between the two requesters; on a tie the one that did not
  // win last time is served. Fetch never competes while halted.
  logic fetch_elig;
  logic grant_fetch;
  logic grant_load;

  assign fetch_elig  = fetch_req && !halted_q;
  assign grant_fetch = fetch_elig && (!load_req || last_load_q);
  assign grant_load  = load_req && !grant_fetch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rd_wait_q     <= 1'b0;
      last_load_q   <= 1'b1;
      ret_halt_q    <= 1'b0;
      clr_pend_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      load_err_q    <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
`ifdef NULL_HALT_EN
      halt_addr_q   <= '0;
`endif
    end else begin
      // Pulse outputs are high for exactly one cycle per transaction.
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      load_err_q    <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_fetch) begin
            last_load_q <= 1'b0;
            if (f_in) begin
              state_q    <= F_ACC;
              rd_wait_q  <= 1'b0;
              mem_en_q   <= 1'b1;
              mem_addr_q <= f_off[AW-1:0];
            end else begin
              // Out of range: answer immediately, no RAM access.
              state_q       <= F_RSP;
              fetch_valid_q <= 1'b1;
              fetch_err_q   <= 1'b1;
              fetch_data_q  <= '0;
            end
          end else if (grant_load) begin
            last_load_q <= 1'b1;
            ret_halt_q  <= 1'b0;
            state_q     <= L_WR;
            load_ack_q  <= 1'b1;
            if (l_in) begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= l_off[AW-1:0];
              mem_wdata_q <= load_data;
            end else begin
              load_err_q <= 1'b1;
            end
          end
        end

        F_ACC: begin
          // First cycle the RAM samples the command; second cycle the read
          // data is present and gets captured.
          if (!rd_wait_q) begin
            rd_wait_q <= 1'b1;
          end else begin
            rd_wait_q     <= 1'b0;
            state_q       <= F_RSP;
            fetch_valid_q <= 1'b1;
            fetch_data_q  <= mem_rdata;
`ifdef NULL_HALT_EN
            if (mem_rdata == 32'h0) begin
              halted_q    <= 1'b1;
              halt_addr_q <= fetch_addr;
            end
`endif
          end
        end

        F_RSP: begin
          state_q <= halted_q ? HALT : IDLE;
        end

        L_WR: begin
          if (ret_halt_q && clr_pend_q) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end else if (ret_halt_q) begin
            state_q <= HALT;
          end else begin
            state_q <= IDLE;
          end
          ret_halt_q <= 1'b0;
          clr_pend_q <= 1'b0;
        end

        HALT: begin
          if (load_req) begin
            // Serve the load first; a simultaneous clear is remembered.
            ret_halt_q <= 1'b1;
            clr_pend_q <= halt_clr;
            state_q    <= L_WR;
            load_ack_q <= 1'b1;
            if (l_in) begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= l_off[AW-1:0];
              mem_wdata_q <= load_data;
            end else begin
              load_err_q <= 1'b1;
            end
          end else if (halt_clr) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;
  assign load_ack    = load_ack_q;
  assign load_err    = load_err_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

`ifdef NULL_HALT_EN
  assign halted    = halted_q;
  assign halt_addr = halt_addr_q;
`else
  assign halted    = 1'b0;
  assign halt_addr = '0;
`endif

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Controller for the single-ported instruction memory. It arbitrates between the CPU fetch port (read) and the program-loader port (write), and translates 30-bit word addresses into memory-local offsets with a bounds check. Zero-word (null-op) detection latches a halt that stops further fetches. It sits between the fetch stage, the boot/test loader and the synchronous-read instruction RAM.

Parameters:
BASE, 30'h00100000, first valid word address of instruction space
DEPTH, 145, number of 32-bit words (BASE..BASE+DEPTH-1)
AW, 8, memory-local address width; requires 2**AW >= DEPTH

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request; held with fetch_addr until fetch_valid
fetch_addr  in  30  word address to fetch
fetch_valid  out  1  one-cycle pulse: fetch_data/fetch_err valid
fetch_data  out  32  fetched instruction word
fetch_err  out  1  with fetch_valid: address out of range
load_req  in  1  write request; held with load_addr/load_data until load_ack
load_addr  in  30  word address to write
load_data  in  32  word to write
load_ack  out  1  one-cycle pulse: write done or rejected
load_err  out  1  with load_ack: address out of range, no write
halt_clr  in  1  clears halt state
halted  out  1  null-op halt latched
halt_addr  out  30  fetch address that returned the zero word
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory-local word offset (addr - BASE)
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid the cycle after a mem_en=1, mem_we=0 access

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; last_grant=LOAD, so fetch wins the first tie. Reset mid-access discards the transaction; no valid/ack is issued.
- In range = (addr >= BASE) and (addr - BASE < DEPTH), using 30-bit unsigned arithmetic.
- States: IDLE, F_ACC, F_RSP, L_WR, HALT.
- IDLE arbitration:
  - Fetch is eligible only when not halted.
  - Single eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant, then update last_grant.
- Fetch in range: IDLE -> F_ACC, with mem_en=1, mem_we=0, mem_addr=offset. F_ACC -> F_RSP: capture mem_rdata into fetch_data and pulse fetch_valid. F_RSP -> IDLE.
  - Latency: request sampled at edge N, fetch_valid high in the cycle after edge N+2.
- Fetch out of range: IDLE -> F_RSP directly, with no memory access; fetch_valid=1, fetch_err=1, fetch_data=0.
- Load in range: IDLE -> L_WR. L_WR drives mem_en=1, mem_we=1, mem_addr, mem_wdata=load_data, and load_ack=1 in the same cycle. L_WR -> IDLE.
- Load out of range: L_WR with mem_en=0 and load_ack=1, load_err=1.
- mem_en, mem_we, fetch_valid and load_ack are registered pulses, high exactly one cycle per transaction.
- Requesters may deassert req only after valid/ack. A req still high in the cycle after valid/ack is treated as a new request.
- HALT:
  - Fetch is not granted; fetch_req is left pending with no response.
  - Loads are still served: HALT -> L_WR -> HALT.
  - halt_clr=1 -> IDLE, halted=0, halt_addr kept. If halt_clr coincides with a pending load, the load is served first and the clear takes effect on return.
- halt_clr outside HALT is ignored.

Optional Feature:
NULL_HALT_EN
- Defined: in F_ACC, if mem_rdata == 32'h0, then fetch_valid=1 with fetch_data=0, halted=1 and halt_addr=fetch_addr; next state is HALT instead of IDLE.
- Undefined: zero words are returned as normal data; halted and halt_addr are tied to 0; the HALT state and halt_clr are unused.

Test Plan:
- Fetch 0x00100003, RAM[3]=32'h2008000A -> after 3 cycles, one fetch_valid pulse with fetch_data=32'h2008000A, fetch_err=0; mem_addr=3 while mem_en=1.
- Load 0x00100010 with 32'hDEADBEEF, then fetch the same address -> load_ack one cycle, mem_we pulse at mem_addr=0x10; fetch returns 32'hDEADBEEF.
- fetch_req and load_req both held high for 4 transactions -> grants alternate F, L, F, L after reset; no lost or duplicate ack/valid.
- Fetch 0x000FFFFF and load 0x00100091 -> fetch_err=1, data 0, load_err=1; mem_en stays 0 throughout.
- NULL_HALT_EN, RAM[5]=0, fetch 0x00100005 -> halted=1, halt_addr=0x00100005; the next fetch gets no response; a load is still acked; halt_clr -> fetch served again.
- reset_n low during F_ACC -> all outputs 0 immediately; no fetch_valid; after release the first request is served normally.
